controle_tentativas: RTL

CONTROLE_TENTATIVAS -- requirements
Module: controle_tentativas

---
 rtl/controle_tentativas.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/controle_tentativas.sv
// controle_tentativas: 4-digit BCD keypad lock with attempt counting and timed lockout.
// Define ENTRY_TIMEOUT_EN to discard a partial entry after ENTRY_TIMEOUT idle cycles.
module controle_tentativas #(
    parameter int OPEN_TIME     = 16,
    parameter int LOCK_TIME     = 64,
    parameter int ENTRY_TIMEOUT = 100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  digit,
    input  logic        digit_valid,
    input  logic [15:0] senha,
    output logic        add,
    output logic        cnt_clr,
    input  logic [1:0]  s,
    output logic        unlocked,
    output logic        locked_out
);

    localparam int OPEN_T  = (OPEN_TIME < 1) ? 1 : OPEN_TIME;
    localparam int LOCK_T  = (LOCK_TIME < 1) ? 1 : LOCK_TIME;
    localparam int ENTRY_T = (ENTRY_TIMEOUT < 1) ? 1 : ENTRY_TIMEOUT;
    localparam int MAX_A   = (OPEN_T > LOCK_T) ? OPEN_T : LOCK_T;
    localparam int MAX_T   = (MAX_A > ENTRY_T) ? MAX_A : ENTRY_T;
    localparam int TW      = $clog2(MAX_T + 1);

    typedef enum logic [2:0] {IDLE, ENTRY, CHECK, FAIL, OPEN, LOCKOUT} state_t;

    state_t          state_q, state_d;
    logic [15:0]     buf_q, buf_d;
    logic [1:0]      idx_q, idx_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            add_q, add_d;
    logic            cnt_clr_q, cnt_clr_d;
    logic            unlocked_q, unlocked_d;
    logic            locked_out_q, locked_out_d;
    logic            accept;

    assign accept     = digit_valid && (digit <= 4'd9);
    assign add        = add_q;
    assign cnt_clr    = cnt_clr_q;
    assign unlocked   = unlocked_q;
    assign locked_out = locked_out_q;

    // The single timer is reused: OPEN/LOCKOUT length, FAIL phase, and entry inactivity.
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        idx_d   = idx_q;
        timer_d = timer_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    buf_d   = {buf_q[11:0], digit};
                    idx_d   = idx_q + 2'd1;
                    timer_d = '0;
                    state_d = ENTRY;
                end
            end
            ENTRY: begin
                if (accept) begin
                    buf_d   = {buf_q[11:0], digit};
                    idx_d   = idx_q + 2'd1;
                    timer_d = '0;
                    if (idx_q == 2'd3) state_d = CHECK;
                end
`ifdef ENTRY_TIMEOUT_EN
                else if (timer_q == TW'(ENTRY_T - 1)) begin
                    state_d = IDLE;
                    buf_d   = '0;
                    idx_d   = '0;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
`endif
            end
            CHECK: begin
                timer_d = '0;
                state_d = (buf_q == senha) ? OPEN : FAIL;
            end
            FAIL: begin
                // Second FAIL cycle sees the counter value updated by the add pulse.
                if (timer_q == TW'(1)) begin
                    state_d = (s == 2'd3) ? LOCKOUT : IDLE;
                    timer_d = '0;
                    buf_d   = '0;
                    idx_d   = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            OPEN: begin
                if (timer_q == TW'(OPEN_T - 1)) begin
                    state_d = IDLE;
                    timer_d = '0;
                    buf_d   = '0;
                    idx_d   = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            LOCKOUT: begin
                if (timer_q == TW'(LOCK_T - 1)) begin
                    state_d = IDLE;
                    timer_d = '0;
                    buf_d   = '0;
                    idx_d   = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
                buf_d   = '0;
                idx_d   = '0;
            end
        endcase

        add_d        = (state_q == CHECK) && (state_d == FAIL);
        cnt_clr_d    = ((state_q == CHECK) && (state_d == OPEN)) ||
                       ((state_d == LOCKOUT) && (timer_d == TW'(LOCK_T - 1)));
        unlocked_d   = (state_d == OPEN);
        locked_out_d = (state_d == LOCKOUT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            buf_q        <= '0;
            idx_q        <= '0;
            timer_q      <= '0;
            add_q        <= 1'b0;
            cnt_clr_q    <= 1'b0;
            unlocked_q   <= 1'b0;
            locked_out_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            idx_q        <= idx_d;
            timer_q      <= timer_d;
            add_q        <= add_d;
            cnt_clr_q    <= cnt_clr_d;
            unlocked_q   <= unlocked_d;
            locked_out_q <= locked_out_d;
        end
    end

endmodule
